// File: rtl/core_mem_pkg.sv
// Shared types for the core memory-port arbiter: FSM states, port ownership
// and the captured request record presented to the memory macro.
package core_mem_pkg;

    localparam int unsigned CORE_ADDR_W = 32;
    localparam int unsigned CORE_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } arb_owner_t;

    typedef struct packed {
        logic                   we;
        logic [CORE_ADDR_W-1:0] addr;
        logic [CORE_DATA_W-1:0] wdata;
    } mem_rec_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive fetch losses; at_limit_o forces the next
// contended arbitration in favour of fetch.
module mem_arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [3:0] LIMIT_C = 4'(LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported memory: one
// outstanding access, data priority, bounded fetch starvation.
module mem_port_arbiter
    import core_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = CORE_ADDR_W,
    parameter int unsigned DATA_W       = CORE_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The request record is sized by the package, so the port widths must match it.
    if ((ADDR_W != CORE_ADDR_W) || (DATA_W != CORE_DATA_W)) begin : g_width_check
        $error("mem_port_arbiter: ADDR_W/DATA_W must match core_mem_pkg widths");
    end
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_limit_check
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
    end

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    mem_rec_t   req_q,   req_d;

    logic starve_inc;
    logic starve_clr;
    logic starve_at_limit;
    logic rsp_fire;
    logic issuing;

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (starve_inc),
        .clr_i      (starve_clr),
        .at_limit_o (starve_at_limit)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        req_d      = req_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        rsp_fire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Grants are combinational pulses, so hold them off while reset is asserted.
                if (!reset) begin
                    if (d_req && !(if_req && starve_at_limit)) begin
                        d_gnt      = 1'b1;
                        req_d      = '{we: d_we, addr: d_addr, wdata: d_wdata};
                        owner_d    = OWN_D;
                        state_d    = ISSUE;
                        starve_inc = if_req;
                    end else if (if_req) begin
                        if_gnt     = 1'b1;
                        req_d      = '{we: 1'b0, addr: if_addr, wdata: '0};
                        owner_d    = OWN_I;
                        state_d    = ISSUE;
                        starve_clr = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        rsp_fire = 1'b1;
                        state_d  = IDLE;
                        owner_d  = OWN_NONE;
                    end else begin
                        state_d  = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rvalid) begin
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
                    owner_d  = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            req_q   <= req_d;
        end
    end

    assign issuing   = (state_q == ISSUE);
    assign mem_req   = issuing;
    assign mem_we    = issuing & req_q.we;
    assign mem_addr  = issuing ? req_q.addr  : '0;
    assign mem_wdata = issuing ? req_q.wdata : '0;

    assign if_rvalid = rsp_fire && (owner_q == OWN_I);
    assign d_rvalid  = rsp_fire && (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    // Store acknowledges carry no data even if the memory drives its read bus.
    assign d_rdata   = (d_rvalid && !req_q.we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle-by-cycle bench for mem_port_arbiter; the bench plays the
// memory macro and both requesters.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; combinational outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".if_gnt"},    64'(if_gnt),    64'd0);
        chk({tag, ".d_gnt"},     64'(d_gnt),     64'd0);
        chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'd0);
        chk({tag, ".d_rvalid"},  64'(d_rvalid),  64'd0);
        chk({tag, ".mem_req"},   64'(mem_req),   64'd0);
        chk({tag, ".mem_addr"},  64'(mem_addr),  64'd0);
        chk({tag, ".mem_we"},    64'(mem_we),    64'd0);
    endtask

    initial begin
        reset = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
        d_addr = '0; d_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        settle();
        chk_quiet("rst_state");

        // Reset while a D load waits for its response; the late response is dropped.
        d_req = 1; d_we = 0; d_addr = 32'h40;
        settle();
        chk("rst.d_gnt", 64'(d_gnt), 64'd1);
        tick();
        d_req = 0;
        settle();
        chk("rst.mem_req", 64'(mem_req), 64'd1);
        chk("rst.mem_addr", 64'(mem_addr), 64'h40);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        settle();
        chk("rst.wait_mem_req", 64'(mem_req), 64'd0);
        reset = 1;
        settle();
        chk_quiet("rst_async");
        tick();
        reset = 0;
        tick();
        mem_rvalid = 1; mem_rdata = 32'h1234;
        settle();
        chk_quiet("rst_late_rsp");
        tick();
        mem_rvalid = 0;
        $display("txn reset-mid-wait: late response dropped");

        // Fetch alone, memory grants on the second ISSUE cycle.
        if_req = 1; if_addr = 32'h100;
        settle();
        chk("if1.if_gnt", 64'(if_gnt), 64'd1);
        chk("if1.d_gnt", 64'(d_gnt), 64'd0);
        tick();
        if_req = 0;
        settle();
        chk("if1.mem_req", 64'(mem_req), 64'd1);
        chk("if1.mem_addr", 64'(mem_addr), 64'h100);
        chk("if1.mem_we", 64'(mem_we), 64'd0);
        chk("if1.if_gnt_pulse", 64'(if_gnt), 64'd0);
        tick();
        chk("if1.mem_req_hold", 64'(mem_req), 64'd1);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        settle();
        chk("if1.mem_req_drop", 64'(mem_req), 64'd0);
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        settle();
        chk("if1.if_rvalid", 64'(if_rvalid), 64'd1);
        chk("if1.if_rdata", 64'(if_rdata), 64'hDEADBEEF);
        chk("if1.d_rvalid", 64'(d_rvalid), 64'd0);
        tick();
        mem_rvalid = 0;
        settle();
        chk("if1.if_rvalid_end", 64'(if_rvalid), 64'd0);
        $display("txn fetch 0x100 -> 0x%08h", 32'hDEADBEEF);

        // Contention: the store wins first, fetch follows on the next IDLE.
        if_req = 1; if_addr = 32'h300;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h55;
        settle();
        chk("st.d_gnt", 64'(d_gnt), 64'd1);
        chk("st.if_gnt", 64'(if_gnt), 64'd0);
        tick();
        d_req = 0;
        settle();
        chk("st.mem_we", 64'(mem_we), 64'd1);
        chk("st.mem_addr", 64'(mem_addr), 64'h2000);
        chk("st.mem_wdata", 64'(mem_wdata), 64'h55);
        chk("st.if_gnt_blocked", 64'(if_gnt), 64'd0);
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        mem_rvalid = 1; mem_rdata = 32'hAAAA_AAAA;
        settle();
        chk("st.d_rvalid", 64'(d_rvalid), 64'd1);
        chk("st.d_rdata", 64'(d_rdata), 64'd0);
        chk("st.if_rvalid", 64'(if_rvalid), 64'd0);
        tick();
        mem_rvalid = 0;
        settle();
        chk("st.then_if_gnt", 64'(if_gnt), 64'd1);
        tick();
        if_req = 0;
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h77;
        settle();
        chk("st.if_rvalid", 64'(if_rvalid), 64'd1);
        chk("st.if_rdata", 64'(if_rdata), 64'h77);
        tick();
        mem_gnt = 0; mem_rvalid = 0;
        $display("txn store 0x2000<=0x55 then fetch 0x300 -> 0x77");

        // Starvation: D wins 4 times, I takes the 5th; twice to show the count restarts.
        if_req = 1; if_addr = 32'h400;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) begin
                d_req = 1; d_we = 0; d_addr = 32'h800 + 32'(k);
                settle();
                chk($sformatf("starve.r%0d.k%0d.d_gnt", r, k), 64'(d_gnt), (k < 4) ? 64'd1 : 64'd0);
                chk($sformatf("starve.r%0d.k%0d.if_gnt", r, k), 64'(if_gnt), (k < 4) ? 64'd0 : 64'd1);
                tick();
                d_req = 0;
                mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hF000 + 32'(k);
                settle();
                chk($sformatf("starve.r%0d.k%0d.d_rvalid", r, k), 64'(d_rvalid), (k < 4) ? 64'd1 : 64'd0);
                chk($sformatf("starve.r%0d.k%0d.if_rvalid", r, k), 64'(if_rvalid), (k < 4) ? 64'd0 : 64'd1);
                tick();
                mem_gnt = 0; mem_rvalid = 0;
                $display("txn starve round %0d slot %0d -> %s", r, k, (k < 4) ? "D" : "I");
            end
        end
        if_req = 0;
        settle();

        // Zero-latency memory, back-to-back loads: two cycles each, no duplicates.
        for (int k = 0; k < 3; k++) begin
            d_req = 1; d_we = 0; d_addr = 32'h500 + 32'(4 * k);
            settle();
            chk($sformatf("zl.%0d.d_gnt", k), 64'(d_gnt), 64'd1);
            tick();
            d_req = 0;
            mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hC0DE0000 + 32'(k);
            settle();
            chk($sformatf("zl.%0d.mem_addr", k), 64'(mem_addr), 64'(32'h500 + 32'(4 * k)));
            chk($sformatf("zl.%0d.d_rvalid", k), 64'(d_rvalid), 64'd1);
            chk($sformatf("zl.%0d.d_rdata", k), 64'(d_rdata), 64'(32'hC0DE0000 + 32'(k)));
            chk($sformatf("zl.%0d.if_rvalid", k), 64'(if_rvalid), 64'd0);
            tick();
            mem_gnt = 0; mem_rvalid = 0;
            $display("txn zero-latency load 0x%0h -> 0x%08h", 32'h500 + 32'(4 * k), 32'hC0DE0000 + 32'(k));
        end
        settle();
        chk("zl.no_dup", 64'(d_rvalid), 64'd0);

        // D request withdrawn while fetch is in ISSUE: never granted, fetch completes.
        if_req = 1; if_addr = 32'h600;
        settle();
        chk("drop.if_gnt", 64'(if_gnt), 64'd1);
        tick();
        if_req = 0;
        d_req = 1; d_we = 0; d_addr = 32'h900;
        settle();
        chk("drop.d_gnt_issue", 64'(d_gnt), 64'd0);
        chk("drop.mem_addr", 64'(mem_addr), 64'h600);
        tick();
        chk("drop.d_gnt_issue2", 64'(d_gnt), 64'd0);
        d_req = 0;
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        mem_rvalid = 1; mem_rdata = 32'h66;
        settle();
        chk("drop.if_rvalid", 64'(if_rvalid), 64'd1);
        chk("drop.if_rdata", 64'(if_rdata), 64'h66);
        chk("drop.d_rvalid", 64'(d_rvalid), 64'd0);
        tick();
        mem_rvalid = 0;
        settle();
        chk_quiet("drop.idle");
        tick();
        chk_quiet("drop.idle2");
        $display("txn fetch 0x600 -> 0x66 with withdrawn D request");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
